// File: rtl/spi_port_pkg.sv
// Shared constants for the SPI port: register map, STATUS/CTRL bit positions
// and the transfer sequencer state encoding.
package spi_port_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_COUNT  = 2'd3;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_RXOVR = 4;

  localparam int CTRL_SS  = 0;
  localparam int CTRL_IRQ = 1;
  localparam int CTRL_W   = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_HI,
    S_WAIT_LO,
    S_DONE
  } state_e;

endpackage

// File: rtl/spi_port_fifo.sv
// Synchronous TX byte FIFO, FIFO_DEPTH x 8, with full/empty/occupancy.
// A push while full is dropped even if a pop happens in the same cycle.
module spi_port_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [7:0]                    din,
  output logic [7:0]                    dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/spi_port.sv
// CPU-facing SPI port: TX FIFO, transfer sequencer for an external byte engine,
// RX holding register and DATA/STATUS/CTRL/COUNT registers. Optional irq: SPI_PORT_IRQ_EN.
module spi_port
  import spi_port_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       wr,
  input  logic       rd,
  input  logic [1:0] a,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       spi_start,
  output logic [7:0] spi_din,
  input  logic       spi_bsy,
  input  logic [7:0] spi_dout,
  output logic       sd_cs_n,
  output logic       irq
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [7:0]        spi_din_q, spi_din_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              spi_start_q, spi_start_d;
  logic              rxv_q, rxv_d;
  logic              rxovr_q, rxovr_d;
  logic              ovf_q, ovf_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  logic              fifo_full, fifo_empty, fifo_pop;
  logic [7:0]        fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              wr_data, wr_ctrl, rd_data, rd_status, busy;
  logic [7:0]        status;

  assign wr_data   = cs & wr & (a == ADDR_DATA);
  assign wr_ctrl   = cs & wr & (a == ADDR_CTRL);
  assign rd_data   = cs & rd & (a == ADDR_DATA);
  assign rd_status = cs & rd & (a == ADDR_STATUS);
  assign fifo_pop  = (state_q == S_LOAD);
  assign busy      = (state_q != S_IDLE) | ~fifo_empty;

  spi_port_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_data),
    .pop   (fifo_pop),
    .din   (din),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // spi_start is registered off START so spi_din has settled a full clock
  // before the engine sees the start request.
  always_comb begin
    state_d     = state_q;
    spi_din_d   = spi_din_q;
    spi_start_d = 1'b0;
    rx_data_d   = rx_data_q;
    rxv_d       = rxv_q;
    rxovr_d     = rxovr_q;
    ovf_d       = ovf_q;
    ctrl_d      = ctrl_q;

    if (rd_data) rxv_d = 1'b0;
    if (rd_status) begin
      ovf_d   = 1'b0;
      rxovr_d = 1'b0;
    end
    if (wr_data && fifo_full) ovf_d = 1'b1;
    if (wr_ctrl) begin
      ctrl_d[CTRL_SS] = din[CTRL_SS];
`ifdef SPI_PORT_IRQ_EN
      ctrl_d[CTRL_IRQ] = din[CTRL_IRQ];
`endif
    end

    case (state_q)
      S_IDLE:    if (!fifo_empty) state_d = S_LOAD;
      S_LOAD: begin
        spi_din_d = fifo_head;
        state_d   = S_START;
      end
      S_START: begin
        spi_start_d = 1'b1;
        state_d     = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (spi_bsy) state_d = S_WAIT_LO;
        else         spi_start_d = 1'b1;
      end
      S_WAIT_LO: begin
        if (!spi_bsy) begin
          rx_data_d = spi_dout;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        // A DATA read landing in this cycle consumes the old byte, so no overrun.
        if (rxv_q && !rd_data) rxovr_d = 1'b1;
        rxv_d   = 1'b1;
        state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      spi_din_q   <= '0;
      spi_start_q <= 1'b0;
      rx_data_q   <= '0;
      rxv_q       <= 1'b0;
      rxovr_q     <= 1'b0;
      ovf_q       <= 1'b0;
      ctrl_q      <= '0;
    end else begin
      state_q     <= state_d;
      spi_din_q   <= spi_din_d;
      spi_start_q <= spi_start_d;
      rx_data_q   <= rx_data_d;
      rxv_q       <= rxv_d;
      rxovr_q     <= rxovr_d;
      ovf_q       <= ovf_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign spi_start = spi_start_q;
  assign spi_din   = spi_din_q;
  assign sd_cs_n   = ~ctrl_q[CTRL_SS];

  always_comb begin
    status           = '0;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
    status[ST_BUSY]  = busy;
    status[ST_OVF]   = ovf_q;
    status[ST_RXOVR] = rxovr_q;
  end

  always_comb begin
    dout = '0;
    case (a)
      ADDR_DATA:   dout = rx_data_q;
      ADDR_STATUS: dout = status;
      ADDR_CTRL:   dout = {{(8-CTRL_W){1'b0}}, ctrl_q};
      ADDR_COUNT:  dout = 8'(fifo_count);
      default:     dout = '0;
    endcase
  end

`ifdef SPI_PORT_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = ctrl_q[CTRL_IRQ] & (rxv_q | (fifo_empty & ~busy));
  end

  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_spi_port.sv
// Bench for spi_port: a behavioural byte engine plus scenario tasks checking
// register behaviour and the transmitted/received byte streams.
`timescale 1ns/1ps
module tb_spi_port;

  localparam int FIFO_DEPTH = 4;
  localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_CTRL = 2'd2, A_COUNT = 2'd3;

  logic       clk = 1'b0;
  logic       rst, cs, wr, rd;
  logic [1:0] a;
  logic [7:0] din, dout;
  logic       spi_start;
  logic [7:0] spi_din;
  logic       spi_bsy;
  logic [7:0] spi_dout;
  logic       sd_cs_n, irq;

  int tests_run = 0;
  int fails = 0;

  // engine model controls and logs
  logic       eng_stall;
  logic [7:0] eng_xor;
  int         eng_lat;
  logic [7:0] tx_log[$];
  bit         stable_log[$];
  logic [7:0] eng_byte, din_prev;
  int         eng_cnt;
  logic       start_prev;

  spi_port #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .cs(cs), .wr(wr), .rd(rd), .a(a), .din(din), .dout(dout),
    .spi_start(spi_start), .spi_din(spi_din), .spi_bsy(spi_bsy), .spi_dout(spi_dout),
    .sd_cs_n(sd_cs_n), .irq(irq)
  );

  always #5 clk = ~clk;

  // Byte engine: starts on a spi_start rising edge, stays busy eng_lat+1 clocks
  // (forever while stalled), then returns the sent byte XOR eng_xor.
  always @(posedge clk) begin
    if (rst) begin
      spi_bsy    <= 1'b0;
      spi_dout   <= 8'h00;
      eng_cnt    <= 0;
      start_prev <= 1'b0;
    end else begin
      start_prev <= spi_start;
      if (spi_start && !start_prev && !spi_bsy) begin
        spi_bsy  <= 1'b1;
        eng_byte <= spi_din;
        eng_cnt  <= eng_lat;
        tx_log.push_back(spi_din);
        stable_log.push_back(spi_din == din_prev);
      end else if (spi_bsy && !eng_stall) begin
        if (eng_cnt == 0) begin
          spi_bsy  <= 1'b0;
          spi_dout <= eng_byte ^ eng_xor;
        end else begin
          eng_cnt <= eng_cnt - 1;
        end
      end
    end
    din_prev <= spi_din;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [1:0] addr, input logic [7:0] val);
    cs = 1'b1; wr = 1'b1; a = addr; din = val;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [7:0] val);
    cs = 1'b1; rd = 1'b1; a = addr;
    #1 val = dout;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic peek(input logic [1:0] addr, output logic [7:0] val);
    a = addr;
    #1 val = dout;
  endtask

  task automatic wait_idle(input string tag);
    logic [7:0] s;
    for (int i = 0; i < 400; i++) begin
      peek(A_STATUS, s);
      if (!s[2]) return;
      @(negedge clk);
    end
    tests_run++; fails++;
    $display("FAIL %s_idle_timeout: BUSY=1 after 400 clocks, required 0", tag);
  endtask

  task automatic wait_bsy(input logic level, input string tag);
    for (int i = 0; i < 100; i++) begin
      if (spi_bsy === level) return;
      @(negedge clk);
    end
    tests_run++; fails++;
    $display("FAIL %s_bsy_timeout: spi_bsy=%b, required %b", tag, spi_bsy, level);
  endtask

  task automatic wait_wait_lo(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (spi_bsy === 1'b1 && spi_start === 1'b0) return;
      @(negedge clk);
    end
    tests_run++; fails++;
    $display("FAIL %s_waitlo_timeout: bsy=%b start=%b, required bsy=1 start=0", tag, spi_bsy, spi_start);
  endtask

  task automatic clean_rx();
    logic [7:0] v;
    bus_read(A_DATA, v);
    bus_read(A_STATUS, v);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    peek(A_STATUS, v);
    tests_run++; if (v !== 8'h02) begin fails++; $display("FAIL reset_status: got %h, required 02", v); end
    tests_run++; if (sd_cs_n !== 1'b1) begin fails++; $display("FAIL reset_sd_cs_n: got %b, required 1", sd_cs_n); end
    tests_run++; if (spi_start !== 1'b0) begin fails++; $display("FAIL reset_spi_start: got %b, required 0", spi_start); end
    tests_run++; if (spi_din !== 8'h00) begin fails++; $display("FAIL reset_spi_din: got %h, required 00", spi_din); end
    tests_run++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b, required 0", irq); end
    peek(A_COUNT, v);
    tests_run++; if (v !== 8'h00) begin fails++; $display("FAIL reset_count: got %h, required 00", v); end
    peek(A_CTRL, v);
    tests_run++; if (v !== 8'h00) begin fails++; $display("FAIL reset_ctrl: got %h, required 00", v); end
    peek(A_DATA, v);
    tests_run++; if (v !== 8'h00) begin fails++; $display("FAIL reset_data: got %h, required 00", v); end
  endtask

  task automatic test_single();
    logic [7:0] v;
    int n0;
    bus_write(A_CTRL, 8'h01);
    tests_run++; if (sd_cs_n !== 1'b0) begin fails++; $display("FAIL single_sd_cs_n: got %b, required 0", sd_cs_n); end
    eng_xor = 8'h00; eng_lat = 3;
    n0 = tx_log.size();
    bus_write(A_DATA, 8'hA5);
    wait_idle("single");
    tests_run++;
    if (tx_log.size() != n0 + 1 || tx_log[n0] !== 8'hA5 || !stable_log[n0]) begin
      fails++; $display("FAIL single_tx: sent %0d bytes (first %h, stable %0d), required 1 byte A5 stable", tx_log.size() - n0, (tx_log.size() > n0) ? tx_log[n0] : 8'hxx, (stable_log.size() > n0) ? stable_log[n0] : 0);
    end
    bus_read(A_DATA, v);
    tests_run++; if (v !== 8'hA5) begin fails++; $display("FAIL single_rx: got %h, required A5", v); end
    bus_write(A_DATA, 8'h3C);
    wait_idle("single2");
    peek(A_STATUS, v);
    tests_run++; if (v[4] !== 1'b0) begin fails++; $display("FAIL single_rxv_cleared: RXOVR=%b, required 0", v[4]); end
    bus_read(A_DATA, v);
    tests_run++; if (v !== 8'h3C) begin fails++; $display("FAIL single_rx2: got %h, required 3C", v); end
  endtask

  task automatic test_regs();
    logic [7:0] v;
    bus_write(A_STATUS, 8'hFF);
    bus_write(A_COUNT, 8'hFF);
    peek(A_STATUS, v);
    tests_run++; if (v !== 8'h02) begin fails++; $display("FAIL regs_status_ro: got %h, required 02", v); end
    peek(A_COUNT, v);
    tests_run++; if (v !== 8'h00) begin fails++; $display("FAIL regs_count_ro: got %h, required 00", v); end
    bus_write(A_CTRL, 8'hFE);
    peek(A_CTRL, v);
`ifdef SPI_PORT_IRQ_EN
    tests_run++; if (v !== 8'h02) begin fails++; $display("FAIL regs_ctrl_rb: got %h, required 02", v); end
`else
    tests_run++; if (v !== 8'h00) begin fails++; $display("FAIL regs_ctrl_rb: got %h, required 00", v); end
`endif
    tests_run++; if (sd_cs_n !== 1'b1) begin fails++; $display("FAIL regs_sd_cs_n: got %b, required 1", sd_cs_n); end
    bus_write(A_CTRL, 8'h01);
  endtask

  task automatic test_overflow();
    logic [7:0] v;
    logic [7:0] exp_tx[5];
    int n0;
    bit ok;
    clean_rx();
    eng_lat = 1; eng_xor = 8'h00; eng_stall = 1'b1;
    n0 = tx_log.size();
    bus_write(A_DATA, 8'hEE);
    wait_wait_lo("ovf");
    for (int i = 1; i <= 4; i++) bus_write(A_DATA, 8'(i));
    peek(A_COUNT, v);
    tests_run++; if (v !== 8'h04) begin fails++; $display("FAIL ovf_count_peak: got %h, required 04", v); end
    peek(A_STATUS, v);
    tests_run++; if (v !== 8'h05) begin fails++; $display("FAIL ovf_status_full: got %h, required 05", v); end
    bus_write(A_DATA, 8'h05);
    peek(A_COUNT, v);
    tests_run++; if (v !== 8'h04) begin fails++; $display("FAIL ovf_count_after: got %h, required 04", v); end
    bus_read(A_STATUS, v);
    tests_run++; if (v !== 8'h0D) begin fails++; $display("FAIL ovf_status_set: got %h, required 0D", v); end
    peek(A_STATUS, v);
    tests_run++; if (v !== 8'h05) begin fails++; $display("FAIL ovf_status_cleared: got %h, required 05", v); end
    // release the engine and land a write on a still-full FIFO during the LOAD (pop) cycle
    eng_stall = 1'b0;
    @(negedge clk);
    wait_bsy(1'b0, "ovf_release");
    repeat (3) @(negedge clk);
    bus_write(A_DATA, 8'h06);
    peek(A_COUNT, v);
    tests_run++; if (v !== 8'h03) begin fails++; $display("FAIL ovf_pop_push_full_count: got %h, required 03", v); end
    peek(A_STATUS, v);
    tests_run++; if (v[3] !== 1'b1) begin fails++; $display("FAIL ovf_pop_push_full_ovf: got %b, required 1", v[3]); end
    wait_idle("ovf");
    exp_tx[0] = 8'hEE; exp_tx[1] = 8'h01; exp_tx[2] = 8'h02; exp_tx[3] = 8'h03; exp_tx[4] = 8'h04;
    ok = (tx_log.size() == n0 + 5);
    for (int i = 0; i < 5 && ok; i++) if (tx_log[n0 + i] !== exp_tx[i]) ok = 0;
    tests_run++; if (!ok) begin fails++; $display("FAIL ovf_tx_stream: sent %0d bytes, required EE 01 02 03 04 only", tx_log.size() - n0); end
    clean_rx();
  endtask

  task automatic test_rxovr();
    logic [7:0] v, b1, b2;
    clean_rx();
    eng_lat = $urandom_range(1, 4); eng_xor = 8'($urandom);
    b1 = 8'($urandom); b2 = 8'($urandom);
    bus_write(A_DATA, b1);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    bus_write(A_DATA, b2);
    wait_idle("rxovr");
    peek(A_STATUS, v);
    tests_run++; if (v !== 8'h12) begin fails++; $display("FAIL rxovr_status: got %h, required 12", v); end
    peek(A_DATA, v);
    tests_run++; if (v !== (b2 ^ eng_xor)) begin fails++; $display("FAIL rxovr_data: got %h, required %h", v, b2 ^ eng_xor); end
    bus_read(A_STATUS, v);
    peek(A_STATUS, v);
    tests_run++; if (v[4] !== 1'b0) begin fails++; $display("FAIL rxovr_clear: RXOVR=%b, required 0", v[4]); end
    clean_rx();
  endtask

  task automatic test_read_at_done();
    logic [7:0] v;
    clean_rx();
    eng_lat = 2; eng_xor = 8'h00;
    bus_write(A_DATA, 8'h11);
    wait_idle("rdone1");
    bus_write(A_DATA, 8'h22);
    wait_bsy(1'b1, "rdone_hi");
    wait_bsy(1'b0, "rdone_lo");
    @(negedge clk);
    bus_read(A_DATA, v);
    tests_run++; if (v !== 8'h22) begin fails++; $display("FAIL rdone_data: got %h, required 22", v); end
    peek(A_STATUS, v);
    tests_run++; if (v[4] !== 1'b0) begin fails++; $display("FAIL rdone_no_rxovr: RXOVR=%b, required 0", v[4]); end
    bus_write(A_DATA, 8'h33);
    wait_idle("rdone3");
    peek(A_STATUS, v);
    tests_run++; if (v[4] !== 1'b1) begin fails++; $display("FAIL rdone_rxv_kept: RXOVR=%b, required 1", v[4]); end
    clean_rx();
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    int n0;
    clean_rx();
    eng_lat = 1; eng_xor = 8'h00; eng_stall = 1'b1;
    bus_write(A_DATA, 8'h77);
    wait_wait_lo("rstmid");
    bus_write(A_DATA, 8'h88);
    rst = 1'b1;
    @(negedge clk);
    tests_run++; if (spi_start !== 1'b0) begin fails++; $display("FAIL rstmid_start: got %b, required 0", spi_start); end
    peek(A_COUNT, v);
    tests_run++; if (v !== 8'h00) begin fails++; $display("FAIL rstmid_count: got %h, required 00", v); end
    peek(A_STATUS, v);
    tests_run++; if (v !== 8'h02) begin fails++; $display("FAIL rstmid_status: got %h, required 02", v); end
    peek(A_DATA, v);
    tests_run++; if (v !== 8'h00) begin fails++; $display("FAIL rstmid_no_capture: got %h, required 00", v); end
    tests_run++; if (sd_cs_n !== 1'b1) begin fails++; $display("FAIL rstmid_sd_cs_n: got %b, required 1", sd_cs_n); end
    rst = 1'b0; eng_stall = 1'b0;
    @(negedge clk);
    n0 = tx_log.size();
    bus_write(A_DATA, 8'h99);
    wait_idle("rstmid");
    peek(A_STATUS, v);
    tests_run++; if (v !== 8'h02) begin fails++; $display("FAIL rstmid_rxv_was_0: status %h, required 02", v); end
    tests_run++;
    if (tx_log.size() != n0 + 1 || tx_log[n0] !== 8'h99) begin
      fails++; $display("FAIL rstmid_tx: sent %0d bytes, required just 99", tx_log.size() - n0);
    end
    clean_rx();
    bus_write(A_CTRL, 8'h01);
  endtask

  task automatic test_random();
    logic [7:0] v, b;
    logic [7:0] exp_q[$];
    logic       cbit;
    int n, n0;
    bit ok;
    for (int it = 0; it < 20; it++) begin
      clean_rx();
      exp_q.delete();
      n = $urandom_range(1, FIFO_DEPTH);
      eng_lat = $urandom_range(1, 4);
      eng_xor = 8'($urandom);
      n0 = tx_log.size();
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        bus_write(A_DATA, b);
        if (k == 0 && (it % 3) == 0) begin
          cbit = 1'($urandom_range(0, 1));
          bus_write(A_CTRL, {7'b0, cbit});
          tests_run++; if (sd_cs_n !== ~cbit) begin fails++; $display("FAIL rand_ctrl_mid it%0d: sd_cs_n=%b, required %b", it, sd_cs_n, ~cbit); end
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_idle("rand");
      ok = (tx_log.size() == n0 + n);
      for (int k = 0; k < n && ok; k++) if (tx_log[n0 + k] !== exp_q[k] || !stable_log[n0 + k]) ok = 0;
      tests_run++; if (!ok) begin fails++; $display("FAIL rand_tx it%0d: sent %0d bytes, required %0d in order with stable spi_din", it, tx_log.size() - n0, n); end
      peek(A_STATUS, v);
      tests_run++; if (v !== ((n >= 2) ? 8'h12 : 8'h02)) begin fails++; $display("FAIL rand_status it%0d: got %h, required %h", it, v, (n >= 2) ? 8'h12 : 8'h02); end
      bus_read(A_DATA, v);
      tests_run++; if (v !== (exp_q[n-1] ^ eng_xor)) begin fails++; $display("FAIL rand_rx it%0d: got %h, required %h", it, v, exp_q[n-1] ^ eng_xor); end
    end
    clean_rx();
    bus_write(A_CTRL, 8'h01);
  endtask

  task automatic test_irq();
    logic [7:0] v;
    clean_rx();
    eng_lat = 2; eng_xor = 8'h00;
    bus_write(A_CTRL, 8'h03);
    @(negedge clk);
`ifdef SPI_PORT_IRQ_EN
    tests_run++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_idle_empty: got %b, required 1", irq); end
    bus_write(A_DATA, 8'h5A);
    @(negedge clk);
    tests_run++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_busy: got %b, required 0", irq); end
    wait_idle("irq");
    @(negedge clk);
    tests_run++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_after_done: got %b, required 1", irq); end
    bus_read(A_DATA, v);
    @(negedge clk);
    tests_run++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_after_read: got %b, required 1", irq); end
    bus_write(A_CTRL, 8'h01);
    @(negedge clk);
    tests_run++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_disabled: got %b, required 0", irq); end
`else
    tests_run++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_tied: got %b, required 0", irq); end
    peek(A_CTRL, v);
    tests_run++; if (v !== 8'h01) begin fails++; $display("FAIL irq_ctrl_bit1: got %h, required 01", v); end
    bus_write(A_DATA, 8'h5A);
    wait_idle("irq");
    @(negedge clk);
    tests_run++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_tied_after_done: got %b, required 0", irq); end
`endif
    clean_rx();
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; wr = 1'b0; rd = 1'b0; a = 2'd0; din = 8'h00;
    eng_stall = 1'b0; eng_lat = 2; eng_xor = 8'h00;
    @(negedge clk);
    test_reset();
    test_single();
    test_regs();
    test_overflow();
    test_rxovr();
    test_read_at_done();
    test_reset_mid();
    test_random();
    test_irq();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
